interrupt_controller: RTL and testbench

- Collects seven interrupt sources, latches them as pending, masks and priority-encodes them onto the 68000 IPL lines.
- Services the CPU interrupt-acknowledge (IACK) cycle with an autovector, or with BERR for a spurious acknowledge.
- Sits beside BusControl; its active-high outputs feed the top-level inverters for IPL0_n..IPL2_n, AVEC_n and BERR_n.

---
 rtl/interrupt_pkg.sv | 15 +
 rtl/irq_sync_edge.sv | 26 ++
 rtl/interrupt_controller.sv | 117 +++++++++++
 tb/tb_interrupt_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_pkg.sv
// interrupt_pkg: shared FSM state, constants and priority helper for interrupt_controller
//   Contents: state_t (IDLE/ACK/HOLD), FC_IACK, NMI_LEVEL, REG_SEL_MASK/REG_SEL_PCLR,
//   highest_level() returning the highest set level (bit i-1 = level i), 0 if none.
package interrupt_pkg;
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    localparam logic [2:0] FC_IACK = 3'b111;
    localparam int NMI_LEVEL = 7;
    localparam logic REG_SEL_MASK = 1'b0;
    localparam logic REG_SEL_PCLR = 1'b1;
    function automatic logic [2:0] highest_level(input logic [6:0] req);
        highest_level = 3'd0;
        for (int i = 0; i < 7; i++)
            if (req[i]) highest_level = 3'(i + 1);
    endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: per-bit multi-flop synchronizer followed by a rising-edge detector
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous inputs
//   rise       : one-cycle pulse per bit when the synchronized value goes 0 -> 1
module irq_sync_edge #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);
    logic [STAGES-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end
    assign rise = sync[STAGES-1] & ~prev;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches 7 edge-triggered IRQs, masks and priority-encodes them onto IPL, services IACK
//   MCLK_IN, RESET_n_IN        : clock, asynchronous active-low reset
//   IRQ_IN                     : raw sources, bit i-1 = level i, level 7 = NMI (never masked)
//   AS_IN, FC_IN, ADDR_IN      : CPU bus; IACK when AS_IN and FC_IN == 3'b111, ADDR_IN = acked level
//   REG_WR_IN, REG_SEL_IN, REG_WDATA_IN : mask write (sel 0) or pending write-1-to-clear (sel 1)
//   IPL_OUT, AVEC_OUT, BERR_OUT : active-high encoded level, autovector, spurious-ack bus error
//   PENDING_OUT, MASK_OUT      : register readback
//   DATA_OUT, DATA_OE_OUT, DTACK_OUT : vector response, only with INTERRUPT_CONTROLLER_VECTORED_EN
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] VECTOR_BASE = 8'h40
) (
    input  logic       MCLK_IN,
    input  logic       RESET_n_IN,
    input  logic [6:0] IRQ_IN,
    input  logic       AS_IN,
    input  logic [2:0] FC_IN,
    input  logic [2:0] ADDR_IN,
    input  logic       REG_WR_IN,
    input  logic       REG_SEL_IN,
    input  logic [6:0] REG_WDATA_IN,
    output logic [2:0] IPL_OUT,
    output logic       AVEC_OUT,
    output logic       BERR_OUT,
    output logic [6:0] PENDING_OUT,
    output logic [6:0] MASK_OUT,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE_OUT,
    output logic       DTACK_OUT
);
    logic [6:0] rise, pending, mask, enable, lvl_bit, clr;
    logic [2:0] lvl;
    logic       valid, iack;
    state_t     state;

    irq_sync_edge #(.WIDTH(7), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (MCLK_IN),
        .rst_n(RESET_n_IN),
        .din  (IRQ_IN),
        .rise (rise)
    );

    assign enable  = {1'b1, mask[NMI_LEVEL-2:0]};
    assign iack    = AS_IN && FC_IN == FC_IACK;
    assign lvl_bit = (lvl == 3'd0) ? 7'd0 : 7'd1 << (lvl - 3'd1);
    assign valid   = state == ACK && |(lvl_bit & pending & enable);
    assign clr     = (valid ? lvl_bit : 7'd0) |
                     ((REG_WR_IN && REG_SEL_IN == REG_SEL_PCLR) ? REG_WDATA_IN : 7'd0);
    assign PENDING_OUT = pending;
    assign MASK_OUT    = mask;

    // A new edge wins over a same-cycle clear; IPL holds its value during an acknowledge
    always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
        if (!RESET_n_IN) begin
            pending <= '0;
            mask    <= '0;
            IPL_OUT <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
            if (REG_WR_IN && REG_SEL_IN == REG_SEL_MASK) mask <= REG_WDATA_IN;
            if (state == IDLE) IPL_OUT <= highest_level(pending & enable);
        end
    end

    always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
        if (!RESET_n_IN) begin
            state    <= IDLE;
            lvl      <= '0;
            AVEC_OUT <= 1'b0;
            BERR_OUT <= 1'b0;
`ifdef INTERRUPT_CONTROLLER_VECTORED_EN
            DATA_OUT    <= '0;
            DATA_OE_OUT <= 1'b0;
            DTACK_OUT   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (iack) begin
                    lvl   <= ADDR_IN;
                    state <= ACK;
                end
                ACK: begin
                    if (valid) begin
`ifdef INTERRUPT_CONTROLLER_VECTORED_EN
                        DATA_OUT    <= VECTOR_BASE + {5'd0, lvl};
                        DATA_OE_OUT <= 1'b1;
                        DTACK_OUT   <= 1'b1;
`else
                        AVEC_OUT <= 1'b1;
`endif
                    end else begin
                        BERR_OUT <= 1'b1;
                    end
                    state <= HOLD;
                end
                HOLD: if (!AS_IN) begin
                    AVEC_OUT <= 1'b0;
                    BERR_OUT <= 1'b0;
`ifdef INTERRUPT_CONTROLLER_VECTORED_EN
                    DATA_OE_OUT <= 1'b0;
                    DTACK_OUT   <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef INTERRUPT_CONTROLLER_VECTORED_EN
    assign DATA_OUT    = VECTOR_BASE & 8'h00;
    assign DATA_OE_OUT = 1'b0;
    assign DTACK_OUT   = 1'b0;
`endif
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: table vectors, directed IACK corner cases and randomized checks against a level model
module tb_interrupt_controller;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [6:0] irq = '0, wdata = '0;
    logic       as_i = 1'b0, reg_wr = 1'b0, reg_sel = 1'b0;
    logic [2:0] fc = '0, addr = '0;
    logic [2:0] ipl;
    logic       avec, berr, oe, dtack;
    logic [6:0] pend, mask;
    logic [7:0] data;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .MCLK_IN(clk), .RESET_n_IN(rst_n), .IRQ_IN(irq), .AS_IN(as_i), .FC_IN(fc),
        .ADDR_IN(addr), .REG_WR_IN(reg_wr), .REG_SEL_IN(reg_sel), .REG_WDATA_IN(wdata),
        .IPL_OUT(ipl), .AVEC_OUT(avec), .BERR_OUT(berr), .PENDING_OUT(pend),
        .MASK_OUT(mask), .DATA_OUT(data), .DATA_OE_OUT(oe), .DTACK_OUT(dtack)
    );

    int nvec = 0, nerr = 0;
    logic [6:0] m_pend = '0, m_mask = '0;

    typedef struct {
        logic [6:0] mask;
        logic [6:0] irq;
        logic [2:0] ipl;
        logic [6:0] pend;
    } vec_t;
    vec_t tbl[7];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] model_ipl();
        for (int l = 7; l >= 1; l--)
            if (m_pend[l-1] && (l == 7 || m_mask[l-1])) return 3'(l);
        return 3'd0;
    endfunction

    function automatic logic model_valid(input logic [2:0] l);
        if (l == 3'd0) return 1'b0;
        return m_pend[l-1] && (l == 3'd7 || m_mask[l-1]);
    endfunction

    task automatic wr(input logic sel, input logic [6:0] d);
        reg_wr = 1'b1; reg_sel = sel; wdata = d;
        tick(1);
        reg_wr = 1'b0;
        if (sel) m_pend &= ~d; else m_mask = d;
    endtask

    task automatic pulse(input logic [6:0] p);
        irq = p;
        tick(4);
        irq = '0;
        tick(4);
        m_pend |= p;
    endtask

    task automatic response(input logic v);
`ifdef INTERRUPT_CONTROLLER_VECTORED_EN
        chk("ack_dtack", 8'(dtack), 8'(v));
        chk("ack_avec", 8'(avec), 8'h00);
`else
        chk("ack_avec", 8'(avec), 8'(v));
`endif
        chk("ack_berr", 8'(berr), 8'(!v));
    endtask

    task automatic iack(input logic [2:0] l, input logic v);
        as_i = 1'b1; fc = 3'b111; addr = l;
        tick(1);
        chk("ack_early", {6'd0, avec, berr}, 8'h00);
        tick(1);
        response(v);
        tick(1);
        response(v);
        as_i = 1'b0; fc = '0;
        tick(1);
        chk("ack_release", {6'd0, avec, berr}, 8'h00);
        tick(1);
        if (v) m_pend[l-1] = 1'b0;
    endtask

    initial begin
        tbl[0] = '{7'h3F, 7'h12, 3'd5, 7'h12};
        tbl[1] = '{7'h00, 7'h08, 3'd0, 7'h08};
        tbl[2] = '{7'h00, 7'h40, 3'd7, 7'h40};
        tbl[3] = '{7'h40, 7'h20, 3'd0, 7'h20};
        tbl[4] = '{7'h7F, 7'h7F, 3'd7, 7'h7F};
        tbl[5] = '{7'h15, 7'h1F, 3'd5, 7'h1F};
        tbl[6] = '{7'h01, 7'h01, 3'd1, 7'h01};

        tick(3);
        chk("rst_ipl", 8'(ipl), 8'h00);
        chk("rst_ackout", {5'd0, avec, berr, oe}, 8'h00);
        chk("rst_dtack", 8'(dtack), 8'h00);
        chk("rst_pend", 8'(pend), 8'h00);
        chk("rst_mask", 8'(mask), 8'h00);
        chk("rst_data", data, 8'h00);
        rst_n = 1'b1;
        tick(1);

        // single source through synchronizer, then autovector ack
        wr(0, 7'h7F);
        irq = 7'h04;
        tick(3);
        chk("s1_pend", 8'(pend), 8'h04);
        chk("s1_ipl_early", 8'(ipl), 8'h00);
        tick(1);
        chk("s1_ipl", 8'(ipl), 8'h03);
        irq = '0;
        tick(4);
        m_pend = 7'h04;
        as_i = 1'b1; fc = 3'b111; addr = 3'd3;
        tick(2);
        response(1'b1);
        chk("s1_pend_clr", 8'(pend), 8'h00);
        as_i = 1'b0; fc = '0;
        tick(2);
        chk("s1_ipl_after", 8'(ipl), 8'h00);
        m_pend = '0;

        // two levels, acked highest first
        wr(0, 7'h3F);
        pulse(7'h12);
        chk("s2_ipl5", 8'(ipl), 8'h05);
        iack(3'd5, 1'b1);
        chk("s2_ipl2", 8'(ipl), 8'h02);
        iack(3'd2, 1'b1);
        chk("s2_ipl0", 8'(ipl), 8'h00);

        for (int i = 0; i < 7; i++) begin
            wr(1, 7'h7F);
            wr(0, tbl[i].mask);
            pulse(tbl[i].irq);
            chk($sformatf("tbl%0d_ipl", i), 8'(ipl), 8'(tbl[i].ipl));
            chk($sformatf("tbl%0d_pend", i), 8'(pend), 8'(tbl[i].pend));
        end
        wr(1, 7'h7F);

        // masked pending stays latched, appears on unmask, W1C removes it
        wr(0, 7'h00);
        pulse(7'h08);
        chk("s3_ipl_masked", 8'(ipl), 8'h00);
        chk("s3_pend", 8'(pend), 8'h08);
        wr(0, 7'h08);
        chk("s3_ipl_lag", 8'(ipl), 8'h00);
        tick(1);
        chk("s3_ipl4", 8'(ipl), 8'h04);
        wr(1, 7'h08);
        tick(1);
        chk("s3_ipl_w1c", 8'(ipl), 8'h00);
        chk("s3_pend_w1c", 8'(pend), 8'h00);

        // NMI ignores mask; spurious ack gives BERR and leaves NMI pending
        wr(0, 7'h00);
        pulse(7'h40);
        chk("s4_ipl7", 8'(ipl), 8'h07);
        iack(3'd3, 1'b0);
        chk("s4_pend", 8'(pend), 8'h40);
        chk("s4_ipl7b", 8'(ipl), 8'h07);
        wr(1, 7'h40);
        tick(1);

        // new edge on the acked level during ACK survives the clear
        wr(0, 7'h08);
        pulse(7'h08);
        chk("s5_ipl4", 8'(ipl), 8'h04);
        irq = 7'h08;
        tick(1);
        iack(3'd4, 1'b1);
        irq = '0;
        tick(4);
        m_pend = 7'h08;
        chk("s5_pend", 8'(pend), 8'h08);
        chk("s5_ipl4b", 8'(ipl), 8'h04);
        wr(1, 7'h7F);
        tick(1);

        // level 6 ack held in HOLD, then asynchronous reset
        wr(0, 7'h3F);
        pulse(7'h20);
        chk("s6_ipl6", 8'(ipl), 8'h06);
        as_i = 1'b1; fc = 3'b111; addr = 3'd6;
        tick(2);
`ifdef INTERRUPT_CONTROLLER_VECTORED_EN
        chk("s6_data", data, 8'h46);
        chk("s6_oe_dtack", {6'd0, oe, dtack}, 8'h03);
        chk("s6_avec", 8'(avec), 8'h00);
`else
        chk("s6_data", data, 8'h00);
        chk("s6_oe_dtack", {6'd0, oe, dtack}, 8'h00);
        chk("s6_avec", 8'(avec), 8'h01);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_out", {4'd0, avec, berr, oe, dtack}, 8'h00);
        chk("s6_rst_ipl", 8'(ipl), 8'h00);
        chk("s6_rst_pend", 8'(pend), 8'h00);
        as_i = 1'b0; fc = '0;
        tick(1);
        rst_n = 1'b1;
        m_pend = '0; m_mask = '0;
        tick(1);

        for (int n = 0; n < 60; n++) begin
            int op;
            logic [2:0] l, f;
            op = $urandom_range(0, 3);
            case (op)
                0: wr(0, 7'($urandom));
                1: wr(1, 7'($urandom));
                2: pulse(7'($urandom));
                default: begin
                    l = 3'($urandom_range(0, 7));
                    f = $urandom_range(0, 1) ? 3'b111 : 3'($urandom_range(0, 6));
                    if (f == 3'b111) iack(l, model_valid(l));
                    else begin
                        as_i = 1'b1; fc = f; addr = l;
                        tick(3);
                        chk("rnd_nonack", {6'd0, avec, berr}, 8'h00);
                        as_i = 1'b0; fc = '0;
                        tick(1);
                    end
                end
            endcase
            tick(1);
            chk("rnd_pend", 8'(pend), 8'(m_pend));
            chk("rnd_mask", 8'(mask), 8'(m_mask));
            chk("rnd_ipl", 8'(ipl), 8'(model_ipl()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
